// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage with stall, flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry so that in_ready is registered.
module pipe_stage_buf #(
    parameter int DATA_W    = 80,
    parameter int STALL_W   = 5,
    parameter int STALL_BIT = 3,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    input  logic [STALL_W-1:0] stall_signal,
    output logic [1:0]        count,
    output logic [CNT_W-1:0]  stall_cycles
);
    logic              w_stl;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_unused_stall;
    logic [DATA_W-1:0] r_main;
    logic              r_main_valid;
    logic [CNT_W-1:0]  r_stall_cycles;
    assign w_stl          = stall_signal[STALL_BIT];
    assign w_unused_stall = ^stall_signal;
    assign out_valid      = r_main_valid & ~w_stl & ~rst;
    assign out_data       = r_main;
    assign w_in_fire      = in_valid & in_ready;
    assign w_out_fire     = out_valid & out_ready;
    assign stall_cycles   = r_stall_cycles;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] r_skid;
    logic              r_skid_valid;
    assign in_ready = ~r_skid_valid & ~w_stl & ~rst;
    assign count    = {r_skid_valid, r_main_valid & ~r_skid_valid};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!w_stl) begin
            if (r_skid_valid) begin
                if (w_out_fire) begin
                    r_main       <= r_skid;
                    r_skid_valid <= 1'b0;
                end
            end else if (w_in_fire && r_main_valid && !w_out_fire) begin
                r_skid       <= in_data;
                r_skid_valid <= 1'b1;
            end else if (w_in_fire) begin
                r_main       <= in_data;
                r_main_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_main_valid <= 1'b0;
            end
        end
    end
`else
    // Accepting while full relies on the same-cycle drain, hence the out_ready path.
    assign in_ready = (~r_main_valid | out_ready) & ~w_stl & ~rst;
    assign count    = {1'b0, r_main_valid};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (!w_stl) begin
            if (w_in_fire) begin
                r_main       <= in_data;
                r_main_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_main_valid <= 1'b0;
            end
        end
    end
`endif
    // Counts every stalled cycle, flushed or not; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (w_stl && !(&r_stall_cycles))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed self-checking bench for pipe_stage_buf.
module tb_pipe_stage_buf;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [79:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [79:0] out_data;
    logic        out_ready;
    logic        flush;
    logic [4:0]  stall_signal;
    logic [1:0]  count;
    logic [15:0] stall_cycles;
    int          n_pass = 0;
    int          n_total = 0;

    pipe_stage_buf dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
        .stall_signal(stall_signal), .count(count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; in_valid = 1; in_data = 80'h99; out_ready = 1; flush = 0; stall_signal = 0;
        step(3);
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (count !== 2'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_total++; if (out_data !== 80'h0) $display("FAIL reset_out_data got %0h want 0", out_data); else n_pass++;
        n_total++; if (stall_cycles !== 16'h0) $display("FAIL reset_stall_cycles got %0h want 0", stall_cycles); else n_pass++;
        rst = 0; in_valid = 0;
        step();
    endtask

    task automatic test_first;
        in_valid = 1; in_data = 80'h11; out_ready = 1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL first_in_ready got %0b want 1", in_ready); else n_pass++;
        step();
        in_valid = 0;
        #1;
        n_total++; if (out_valid !== 1'b1) $display("FAIL first_out_valid got %0b want 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 80'h11) $display("FAIL first_out_data got %0h want 11", out_data); else n_pass++;
        n_total++; if (count !== 2'd1) $display("FAIL first_count got %0d want 1", count); else n_pass++;
        step();
        n_total++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL first_drain count %0d valid %0b want 0 0", count, out_valid); else n_pass++;
    endtask

    task automatic test_stream;
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_data = 80'(i);
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready item %0d got %0b want 1", i, in_ready); else n_pass++;
            step();
            n_total++; if (out_valid !== 1'b1 || out_data !== 80'(i)) $display("FAIL stream_out item %0d got valid %0b data %0h want 1 %0h", i, out_valid, out_data, i); else n_pass++;
        end
        in_valid = 0;
        step();
        n_total++; if (count !== 2'd0) $display("FAIL stream_end_count got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_backpressure;
        out_ready = 0; in_valid = 1; in_data = 80'hA;
        step();
        in_data = 80'hB;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_one got %0b want 1", in_ready); else n_pass++;
        step();
        in_valid = 0;
        #1;
        n_total++; if (count !== 2'd2) $display("FAIL bp_count_full got %0d want 2", count); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got %0b want 0", in_ready); else n_pass++;
        out_ready = 1;
        #1;
        n_total++; if (out_valid !== 1'b1 || out_data !== 80'hA) $display("FAIL bp_first_out got %0b %0h want 1 a", out_valid, out_data); else n_pass++;
        step();
        n_total++; if (count !== 2'd1 || out_data !== 80'hB) $display("FAIL bp_second_out count %0d data %0h want 1 b", count, out_data); else n_pass++;
        step();
        n_total++; if (count !== 2'd0) $display("FAIL bp_drained got %0d want 0", count); else n_pass++;
`else
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_one got %0b want 0", in_ready); else n_pass++;
        step();
        in_valid = 0;
        #1;
        n_total++; if (count !== 2'd1 || out_data !== 80'hA) $display("FAIL bp_hold count %0d data %0h want 1 a", count, out_data); else n_pass++;
        out_ready = 1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_passthrough_ready got %0b want 1", in_ready); else n_pass++;
        step();
        n_total++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL bp_drained count %0d valid %0b want 0 0", count, out_valid); else n_pass++;
`endif
    endtask

    task automatic test_stall;
        out_ready = 0; in_valid = 1; in_data = 80'h55;
        step();
        in_data = 80'h66; out_ready = 1; stall_signal = 5'b10111;
        #1;
        n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b1) $display("FAIL stall_other_bits valid %0b ready %0b want 1 1", out_valid, in_ready); else n_pass++;
        in_valid = 0; stall_signal = 5'b01000; in_valid = 1;
        #1;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL stall_outputs valid %0b ready %0b want 0 0", out_valid, in_ready); else n_pass++;
        step(3);
        n_total++; if (count !== 2'd1 || out_data !== 80'h55) $display("FAIL stall_hold count %0d data %0h want 1 55", count, out_data); else n_pass++;
        n_total++; if (stall_cycles !== 16'd3) $display("FAIL stall_cycles got %0d want 3", stall_cycles); else n_pass++;
        stall_signal = 0; in_valid = 0;
        #1;
        n_total++; if (out_valid !== 1'b1 || out_data !== 80'h55) $display("FAIL stall_release got %0b %0h want 1 55", out_valid, out_data); else n_pass++;
        step();
        n_total++; if (count !== 2'd0 || stall_cycles !== 16'd3) $display("FAIL stall_after count %0d cycles %0d want 0 3", count, stall_cycles); else n_pass++;
    endtask

    task automatic test_flush;
        out_ready = 0; in_valid = 1; in_data = 80'h77;
        step();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 80'h78;
        step();
        n_total++; if (count !== 2'd2) $display("FAIL flush_prefill got %0d want 2", count); else n_pass++;
`endif
        flush = 1; stall_signal = 5'b01000; in_data = 80'h88;
        step();
        flush = 0; stall_signal = 0; in_valid = 0; out_ready = 1;
        #1;
        n_total++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_empty count %0d valid %0b want 0 0", count, out_valid); else n_pass++;
        n_total++; if (out_data !== 80'h77) $display("FAIL flush_data_hold got %0h want 77", out_data); else n_pass++;
        n_total++; if (stall_cycles !== 16'd4) $display("FAIL flush_keeps_cycles got %0d want 4", stall_cycles); else n_pass++;
        step(2);
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_dropped got valid %0b data %0h want 0", out_valid, out_data); else n_pass++;
        in_valid = 1; in_data = 80'h33;
        step();
        in_valid = 1; in_data = 80'h99; flush = 1;
        step();
        flush = 0; in_valid = 0;
        #1;
        n_total++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_transfer count %0d valid %0b want 0 0", count, out_valid); else n_pass++;
    endtask

    task automatic test_reset_override;
        out_ready = 0; in_valid = 1; in_data = 80'h21;
        step();
        n_total++; if (count !== 2'd1) $display("FAIL rst_ovr_prefill got %0d want 1", count); else n_pass++;
        rst = 1; in_data = 80'h22; stall_signal = 5'b01000; flush = 1;
        step();
        rst = 0; in_valid = 0; stall_signal = 0; flush = 0;
        #1;
        n_total++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL rst_ovr_state count %0d valid %0b want 0 0", count, out_valid); else n_pass++;
        n_total++; if (stall_cycles !== 16'd0 || out_data !== 80'h0) $display("FAIL rst_ovr_clear cycles %0d data %0h want 0 0", stall_cycles, out_data); else n_pass++;
    endtask

    task automatic test_saturate;
        stall_signal = 5'b01000;
        step(65534);
        n_total++; if (stall_cycles !== 16'hFFFE) $display("FAIL sat_below got %0h want fffe", stall_cycles); else n_pass++;
        step(7);
        n_total++; if (stall_cycles !== 16'hFFFF) $display("FAIL sat_hold got %0h want ffff", stall_cycles); else n_pass++;
        stall_signal = 0;
        step();
        n_total++; if (stall_cycles !== 16'hFFFF) $display("FAIL sat_release got %0h want ffff", stall_cycles); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first();
        test_stream();
        test_backpressure();
        test_stall();
        test_flush();
        test_reset_override();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
